// File: rtl/aes_iter_cipher.sv
// rtl/aes_iter_cipher.sv - iterative AES forward cipher, one round per clock
// Consumes an externally expanded key schedule; round key 0 sits in the top bits of w.
module aes_iter_cipher #(
  parameter int Nk = 8,
  parameter int Nr = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            plaintext,
  input  logic [128*(Nr+1)-1:0]   w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            ciphertext,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] LAST  = 4'(Nk + 6);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   fsm;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [127:0] rk;
  logic [127:0] sbv;
  logic [127:0] srv;
  logic [127:0] mcv;
  logic [127:0] round_v;
  logic [127:0] final_v;
  logic         accept;

  assign in_ready = (fsm == IDLE) | ((fsm == DONE) & out_ready);
  assign busy     = (fsm == ROUND);
  assign accept   = in_valid & in_ready;

  // Byte i of a 128-bit state is s[i%4, i/4]; byte 0 occupies bits [127:120].
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    rk  = '0;
    sbv = '0;
    srv = '0;
    mcv = '0;
    for (int i = 0; i <= Nr; i++) begin
      if (rnd == 4'(i)) rk = w[128*(Nr+1)-1-128*i -: 128];
    end
    for (int i = 0; i < 16; i++) begin
      sbv[127-8*i -: 8] = SBOX[st[127-8*i -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        srv[127-8*(4*c+r) -: 8] = sbv[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = srv[127-32*c -: 8];
      a1 = srv[119-32*c -: 8];
      a2 = srv[111-32*c -: 8];
      a3 = srv[103-32*c -: 8];
      mcv[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mcv[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mcv[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mcv[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    round_v = mcv ^ rk;
    final_v = srv ^ rk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      st         <= '0;
      rnd        <= '0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else if (accept) begin
      // Covers both a fresh start from IDLE and consume-plus-accept in DONE.
      st        <= plaintext ^ w[128*(Nr+1)-1 -: 128];
      rnd       <= 4'd1;
      fsm       <= ROUND;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        ROUND: begin
          if (rnd == LAST) begin
            ciphertext <= final_v;
            out_valid  <= 1'b1;
            rnd        <= '0;
            fsm        <= DONE;
          end else begin
            st  <= round_v;
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        IDLE: fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb/tb_aes_iter_cipher.sv - scoreboard bench for aes_iter_cipher at AES-256/128/192
module tb_aes_iter_cipher;

  typedef struct {
    int           d;
    logic [127:0] e;
  } exp_t;

  localparam int NR_OF [3] = '{14, 10, 12};

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] pt   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ct   [3];
  logic         bsy  [3];
  logic [1919:0] w0;
  logic [1407:0] w1;
  logic [1663:0] w2;

  logic [7:0] tsb [256];
  exp_t       sbq [$];
  int         checks = 0;
  int         errors = 0;

  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PF   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CF   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_iter_cipher #(.Nk(8), .Nr(14)) u256 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .plaintext(pt[0]), .w(w0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .ciphertext(ct[0]), .busy(bsy[0]));
  aes_iter_cipher #(.Nk(4), .Nr(10)) u128 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .plaintext(pt[1]), .w(w1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .ciphertext(ct[1]), .busy(bsy[1]));
  aes_iter_cipher #(.Nk(6), .Nr(12)) u192 (
    .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .plaintext(pt[2]), .w(w2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .ciphertext(ct[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {tsb[v[31:24]], tsb[v[23:16]], tsb[v[15:8]], tsb[v[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) r[1919-32*i -: 32] = wd[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completed outputs are compared when the handshake is about to fire.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && ordy[d] && !rst) begin
        if (sbq.size() == 0) begin
          chk($sformatf("sb_extra%0d", d), 128'(ov[d]), 128'd0);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          chk($sformatf("ct%0d", d), ct[d], x.e);
          chk($sformatf("sb_dut%0d", d), 128'(d), 128'(x.d));
        end
      end
    end
  end

  task automatic wait_out(input int d, output int n, output int bc, input bit hold);
    n = 0; bc = 0;
    while (!ov[d] && n < 40) begin
      if (bsy[d]) bc++;
      iv[d] = hold;
      pt[d] = {$urandom, $urandom, $urandom, $urandom};
      step();
      n++;
    end
    iv[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [127:0] p, input logic [127:0] e, input bit hold);
    exp_t x;
    int n, bc;
    x.d = d; x.e = e;
    sbq.push_back(x);
    chk($sformatf("rdy%0d", d), 128'(ir[d]), 128'd1);
    iv[d] = 1'b1; pt[d] = p;
    step();
    wait_out(d, n, bc, hold);
    chk($sformatf("lat%0d", d), 128'(n), 128'(NR_OF[d]));
    chk($sformatf("busycnt%0d", d), 128'(bc), 128'(NR_OF[d]));
    step();
  endtask

  initial begin
    int   n, bc;
    exp_t x;
    logic [1919:0] full;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      tsb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    w0 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    full = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    w1 = full[1919 -: 1408];
    full = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    w2 = full[1919 -: 1664];
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; pt[d] = '0; ordy[d] = 1'b1;
    end

    rst = 1'b1;
    step(); step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ov%0d", d), 128'(ov[d]), 128'd0);
      chk($sformatf("rst_ct%0d", d), ct[d], 128'd0);
      chk($sformatf("rst_busy%0d", d), 128'(bsy[d]), 128'd0);
      chk($sformatf("rst_rdy%0d", d), 128'(ir[d]), 128'd1);
    end
    rst = 1'b0;
    step();

    run(0, P0, C256, 1'b0);
    run(1, PF, CF, 1'b0);
    run(2, P0, C192, 1'b0);
    full = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    w1 = full[1919 -: 1408];
    run(1, P0, C128, 1'b0);

    // Backpressure: result held while stray in_valid pulses are refused.
    ordy[0] = 1'b0;
    x.d = 0; x.e = C256;
    sbq.push_back(x);
    iv[0] = 1'b1; pt[0] = P0;
    step();
    wait_out(0, n, bc, 1'b0);
    chk("bp_lat", 128'(n), 128'd14);
    for (int k = 0; k < 20; k++) begin
      iv[0] = k[0];
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_rdy", 128'(ir[0]), 128'd0);
      chk("bp_ov", 128'(ov[0]), 128'd1);
      chk("bp_hold", ct[0], C256);
      step();
    end
    sbq.push_back(x);
    iv[0] = 1'b1; pt[0] = P0; ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    chk("bp_ovlow", 128'(ov[0]), 128'd0);
    chk("bp_busy", 128'(bsy[0]), 128'd1);
    wait_out(0, n, bc, 1'b0);
    chk("bp_lat2", 128'(n), 128'd14);
    step();

    // Reset while round 7 is in flight.
    iv[0] = 1'b1; pt[0] = P0;
    step();
    iv[0] = 1'b0;
    repeat (6) step();
    chk("mid_busy_pre", 128'(bsy[0]), 128'd1);
    rst = 1'b1;
    step();
    chk("mid_ov", 128'(ov[0]), 128'd0);
    chk("mid_ct", ct[0], 128'd0);
    chk("mid_busy", 128'(bsy[0]), 128'd0);
    chk("mid_rdy", 128'(ir[0]), 128'd1);
    rst = 1'b0;
    step();
    run(0, P0, C256, 1'b0);

    // in_valid held with changing plaintext through the whole ROUND phase.
    run(0, P0, C256, 1'b1);
    run(2, P0, C192, 1'b1);

    repeat (3) step();
    chk("sb_drain", 128'(sbq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
